// File: rtl/ides_slip.sv
// Serial-to-parallel deserializer with CALIB-driven bit slip for word alignment.
// Define IDES_SLIP_CNT_EN to add the o_slip_cnt alignment-offset output.
module ides_slip #(
  parameter int DW = 4,
  parameter logic [DW-1:0] INIT = {DW{1'b0}}
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_d,
  input  logic          i_calib,
  output logic [DW-1:0] o_q,
  output logic          o_q_valid
`ifdef IDES_SLIP_CNT_EN
  ,
  output logic [$clog2(DW)-1:0] o_slip_cnt
`endif
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] CNT_MAX = CW'(DW - 1);

  generate
    if (!((DW == 4) || (DW == 8) || (DW == 10))) begin : g_bad_dw
      $error("ides_slip: DW must be 4, 8 or 10");
    end
  endgenerate

  logic [DW-1:0] r_sreg;
  logic [DW-1:0] r_q;
  logic [CW-1:0] r_cnt;
  logic          r_calib_d;
  logic          r_slip_pend;
  logic          r_q_valid;

  logic          w_calib_rise;
  logic          w_slip;
  logic [DW-1:0] w_shift;

  assign w_calib_rise = i_calib & ~r_calib_d;
  assign w_slip       = r_slip_pend | w_calib_rise;
  assign w_shift      = {i_d, r_sreg[DW-1:1]};

  // A slip holds the counter for one bit, pushing the word boundary one bit later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_q         <= INIT;
      r_q_valid   <= 1'b0;
      r_slip_pend <= 1'b0;
      r_calib_d   <= i_calib;
    end else begin
      r_calib_d <= i_calib;
      r_q_valid <= 1'b0;
      if (i_ce) begin
        r_sreg <= w_shift;
        if (w_slip) begin
          r_slip_pend <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
          r_q       <= w_shift;
          r_q_valid <= 1'b1;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (w_calib_rise) begin
        r_slip_pend <= 1'b1;
      end
    end
  end

  assign o_q       = r_q;
  assign o_q_valid = r_q_valid;

`ifdef IDES_SLIP_CNT_EN
  logic [CW-1:0] r_slip_cnt;

  // Counts applied slips modulo DW, i.e. the current alignment offset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_slip_cnt <= '0;
    end else if (i_ce && w_slip) begin
      r_slip_cnt <= (r_slip_cnt == CNT_MAX) ? '0 : r_slip_cnt + 1'b1;
    end
  end

  assign o_slip_cnt = r_slip_cnt;
`endif

endmodule

// File: tb/tb_ides_slip.sv
// Self-checking bench for ides_slip: DW=4 (INIT=6) and DW=8 instances.
// Vector table for cycle-exact checks, scoreboard queue for the aligned stream.
module tb_ides_slip;

  typedef struct {
    logic       ce;
    logic       d;
    logic       calib;
    logic       expValid;
    logic [3:0] expQ;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset4, ce4, d4, calib4;
  logic [3:0] q4;
  logic       qValid4;
  logic       reset8, ce8, d8, calib8;
  logic [7:0] q8;
  logic       qValid8;
`ifdef IDES_SLIP_CNT_EN
  logic [1:0] slipCnt4;
  logic [2:0] slipCnt8;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [3:0] expQueue[$];
  logic sbOn = 1'b0;

  always #5 clock = ~clock;

  ides_slip #(.DW(4), .INIT(4'h6)) u4 (
    .i_clk(clock), .i_reset(reset4), .i_ce(ce4), .i_d(d4), .i_calib(calib4),
    .o_q(q4), .o_q_valid(qValid4)
`ifdef IDES_SLIP_CNT_EN
    , .o_slip_cnt(slipCnt4)
`endif
  );

  ides_slip #(.DW(8), .INIT(8'h00)) u8 (
    .i_clk(clock), .i_reset(reset8), .i_ce(ce8), .i_d(d8), .i_calib(calib8),
    .o_q(q8), .o_q_valid(qValid8)
`ifdef IDES_SLIP_CNT_EN
    , .o_slip_cnt(slipCnt8)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic d, input logic calib);
    ce4 = ce;
    d4 = d;
    calib4 = calib;
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus8(input logic ce, input logic d);
    ce8 = ce;
    d8 = d;
    @(posedge clock);
    #1;
  endtask

  task automatic addVec(input logic ce, input logic d, input logic calib,
                        input logic ev, input logic [3:0] eq);
    vec_t v;
    v.ce = ce;
    v.d = d;
    v.calib = calib;
    v.expValid = ev;
    v.expQ = eq;
    vecs.push_back(v);
  endtask

  task automatic reset4Dut(input logic calib);
    reset4 = 1'b1;
    applyStimulus(1'b0, 1'b0, calib);
    reset4 = 1'b0;
  endtask

  // Scoreboard side: every emitted word must match the oldest expected one.
  always @(posedge clock) begin
    #1;
    if (sbOn && qValid4) begin
      if (expQueue.size() == 0) begin
        checkOutput("sb_unexpected_word", {28'h0, q4}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("sb_word", {28'h0, q4}, {28'h0, expQueue.pop_front()});
      end
    end
  end

  initial begin
    bit ev;
    logic [7:0] pat;
    reset4 = 1'b1; ce4 = 1'b0; d4 = 1'b0; calib4 = 1'b0;
    reset8 = 1'b1; ce8 = 1'b0; d8 = 1'b0; calib8 = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("reset_q4", {28'h0, q4}, 32'h6);
    checkOutput("reset_valid4", {31'h0, qValid4}, 32'h0);
    checkOutput("reset_q8", {24'h0, q8}, 32'h0);
    reset4 = 1'b0;

    // Vector table: basic word, CE gap, pending slip set during CE=0 with merged second rise
    addVec(1, 1, 0, 0, 4'h6);
    addVec(1, 0, 0, 0, 4'h6);
    addVec(1, 1, 0, 0, 4'h6);
    addVec(1, 1, 0, 1, 4'hD);
    addVec(0, 0, 0, 0, 4'hD);
    addVec(1, 0, 0, 0, 4'hD);
    addVec(1, 1, 0, 0, 4'hD);
    addVec(1, 1, 0, 0, 4'hD);
    addVec(1, 0, 0, 1, 4'h6);
    addVec(0, 0, 1, 0, 4'h6);
    addVec(0, 0, 1, 0, 4'h6);
    addVec(0, 0, 0, 0, 4'h6);
    addVec(0, 0, 1, 0, 4'h6);
    addVec(1, 1, 1, 0, 4'h6);
    addVec(1, 1, 0, 0, 4'h6);
    addVec(1, 1, 0, 0, 4'h6);
    addVec(1, 1, 0, 0, 4'h6);
    addVec(1, 0, 0, 1, 4'h7);
    addVec(1, 0, 0, 0, 4'h7);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ce, vecs[i].d, vecs[i].calib);
      checkOutput($sformatf("vec%0d_valid", i), {31'h0, qValid4}, {31'h0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d_q", i), {28'h0, q4}, {28'h0, vecs[i].expQ});
    end

    // Aligned stream 1,0,0,0 with one slip at bit 12: gap of 5 then steady 4'h8
    reset4Dut(1'b0);
    sbOn = 1'b1;
    for (int i = 0; i < 28; i++) begin
      ev = (i < 12 && (i % 4) == 3) || (i >= 16 && (i % 4) == 0);
      if (i < 12 && (i % 4) == 3) expQueue.push_back(4'h1);
      if (i >= 16 && (i % 4) == 0) expQueue.push_back(4'h8);
      applyStimulus(1'b1, (i % 4) == 0, i == 12);
      checkOutput($sformatf("stream%0d_valid", i), {31'h0, qValid4}, {31'h0, ev});
    end
    sbOn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("sb_drained", expQueue.size(), 0);
`ifdef IDES_SLIP_CNT_EN
    checkOutput("slip_cnt_one", {30'h0, slipCnt4}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    checkOutput("slip_cnt_wrap", {30'h0, slipCnt4}, 32'h0);
`endif

    // CALIB held high through reset release: no slip, INIT until first word
    reset4Dut(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("hold_q_b0", {28'h0, q4}, 32'h6);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("hold_q_b1", {28'h0, q4}, 32'h6);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("hold_valid_b2", {31'h0, qValid4}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("hold_valid_b3", {31'h0, qValid4}, 32'h1);
    checkOutput("hold_q_b3", {28'h0, q4}, 32'hE);

    // Reset after 2 bits discards the partial word
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    reset4Dut(1'b0);
    checkOutput("midrst_q", {28'h0, q4}, 32'h6);
    checkOutput("midrst_valid", {31'h0, qValid4}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("midrst_early", {31'h0, qValid4}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("midrst_valid_word", {31'h0, qValid4}, 32'h1);
    checkOutput("midrst_q_word", {28'h0, q4}, 32'h6);

    // DW=8 with CE toggling: 0xA5 LSB-first, frozen across CE=0
    reset8 = 1'b0;
    pat = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      applyStimulus8(1'b1, pat[i]);
      checkOutput($sformatf("dw8_on%0d_valid", i), {31'h0, qValid8}, {31'h0, i == 7});
      checkOutput($sformatf("dw8_on%0d_q", i), {24'h0, q8}, (i == 7) ? 32'hA5 : 32'h0);
      applyStimulus8(1'b0, ~pat[i]);
      checkOutput($sformatf("dw8_off%0d_valid", i), {31'h0, qValid8}, 32'h0);
      checkOutput($sformatf("dw8_off%0d_q", i), {24'h0, q8}, (i == 7) ? 32'hA5 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
